// File: rtl/graphic_pkg.sv
// Shared types and constants for the sprite controller front end: write FSM
// states, opcodes and bus widths.
package graphic_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 8;

  localparam logic [7:0] OP_HIGHLIGHT = 8'h01;
  localparam logic [7:0] OP_CONFIRM   = 8'h02;

  typedef enum logic [1:0] {IDLE, WR_HL, WR_CONF, GAP} wr_state_t;

  // Write data layout: opcode in the top byte, selection index in the low byte.
  function automatic logic [DATA_W-1:0] pack_write(input logic [7:0] op,
                                                   input logic [SEL_W-1:0] sel);
    return {op, 16'h0000, sel};
  endfunction

endpackage

// File: rtl/sprite_input_writer_if.sv
// Button inputs and processor-side write port of the sprite controller.
interface sprite_input_writer_if;
  import graphic_pkg::*;

  logic              btn_i;
  logic              btn_confirm_i;
  logic              MW_o;
  logic [ADDR_W-1:0] address_o;
  logic [DATA_W-1:0] data_o;
  logic [SEL_W-1:0]  sel_o;
  logic              busy_o;

  modport master (
    input  btn_i, btn_confirm_i,
    output MW_o, address_o, data_o, sel_o, busy_o
  );

  modport slave (
    output btn_i, btn_confirm_i,
    input  MW_o, address_o, data_o, sel_o, busy_o
  );
endinterface

// File: rtl/button_debouncer.sv
// Synchronizes a raw push-button, debounces it and emits a one-cycle pulse on
// each accepted press. Releases are filtered but produce no pulse.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic            IDLE_LVL = BTN_ACTIVE_LOW;

  logic             sync1, sync2;
  logic             stable;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // level is 1 while the button is physically pressed, whatever the polarity.
  assign level = sync2 ^ IDLE_LVL;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values and the synchronizer chain does not collapse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= IDLE_LVL;
      sync2  <= IDLE_LVL;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (level == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= level;
        cnt    <= '0;
        press  <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_input_writer.sv
// Turns the "next" and "confirm" buttons into single-cycle register writes on
// the sprite controller's processor write port.
module sprite_input_writer
  import graphic_pkg::*;
#(
  parameter int                N_OPTIONS       = 4,
  parameter int                DEBOUNCE_CYCLES = 500000,
  parameter bit                BTN_ACTIVE_LOW  = 1'b1,
  parameter logic [ADDR_W-1:0] HL_ADDR         = 30'h0000_0100,
  parameter logic [ADDR_W-1:0] CONF_ADDR       = 30'h0000_0101
) (
  input  logic                  clk,
  input  logic                  rst,
  sprite_input_writer_if.master bus
);

  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_OPTIONS - 1);

  logic next_press, conf_press;

  wr_state_t         state, next_state;
  logic [SEL_W-1:0]  sel, sel_nxt;
  logic [SEL_W-1:0]  conf_sel, conf_sel_nxt;
  logic              hl_pending, hl_pend_nxt;
  logic              conf_pending, conf_pend_nxt;
  logic              mw;
  logic              busy;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_next_db (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_i),
    .press (next_press)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_conf_db (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_confirm_i),
    .press (conf_press)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    sel_nxt       = sel;
    conf_sel_nxt  = conf_sel;
    hl_pend_nxt   = hl_pending;
    conf_pend_nxt = conf_pending;
    next_state    = state;

    if (next_press) sel_nxt = (sel == SEL_MAX) ? '0 : sel + 1'b1;
    if (conf_press) conf_sel_nxt = sel;

    unique case (state)
      IDLE: begin
        if (conf_pending)    next_state = WR_CONF;
        else if (hl_pending) next_state = WR_HL;
      end
      WR_HL: begin
        hl_pend_nxt = 1'b0;
        next_state  = GAP;
      end
      WR_CONF: begin
        conf_pend_nxt = 1'b0;
        next_state    = GAP;
      end
      GAP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase

    // A press landing on the strobe cycle re-arms the request (set wins).
    if (next_press) hl_pend_nxt   = 1'b1;
    if (conf_press) conf_pend_nxt = 1'b1;
  end

  // Outputs are registered from next-state values so the strobe lines up with
  // the WR_* state and its data matches sel/conf_sel during that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sel          <= '0;
      conf_sel     <= '0;
      hl_pending   <= 1'b0;
      conf_pending <= 1'b0;
      mw           <= 1'b0;
      busy         <= 1'b0;
      address      <= '0;
      data         <= '0;
    end else begin
      state        <= next_state;
      sel          <= sel_nxt;
      conf_sel     <= conf_sel_nxt;
      hl_pending   <= hl_pend_nxt;
      conf_pending <= conf_pend_nxt;
      busy         <= hl_pend_nxt | conf_pend_nxt | (next_state != IDLE);
      mw           <= 1'b0;
      if (next_state == WR_HL) begin
        mw      <= 1'b1;
        address <= HL_ADDR;
        data    <= pack_write(OP_HIGHLIGHT, sel_nxt);
      end else if (next_state == WR_CONF) begin
        mw      <= 1'b1;
        address <= CONF_ADDR;
        data    <= pack_write(OP_CONFIRM, conf_sel_nxt);
      end
    end
  end

  assign bus.MW_o      = mw;
  assign bus.address_o = address;
  assign bus.data_o    = data;
  assign bus.sel_o     = sel;
  assign bus.busy_o    = busy;

endmodule
